// File: rtl/ram_pkg.sv
// Shared types, constants and helpers for the ram_pipe storage primitive.
package ram_pkg;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_IDLE  = 1'b1
    } ram_state_t;

    localparam int BYTE_W = 8;

    // Even parity: the stored bit makes the total number of ones in byte+bit even.
    function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_pipe_if.sv
// Request/response bundle between a client and one ram_pipe instance.
interface ram_pipe_if #(
    parameter int addrwidth = 8,
    parameter int datawidth = 8
);
    localparam int nbytes = datawidth / 8;

    // A request (ren and/or wen) is taken on every rising edge where busy=0;
    // there is no back-pressure beyond busy. Each taken read returns exactly one
    // single-cycle rvalid pulse, in issue order, with data_out/parity_err aligned.
    logic [addrwidth-1:0] address;
    logic                 ren;
    logic                 wen;
    logic [nbytes-1:0]    be;
    logic [datawidth-1:0] data_in;
    logic [datawidth-1:0] data_out;
    logic                 rvalid;
    logic                 busy;
    logic                 parity_err;

    modport master (
        output address, ren, wen, be, data_in,
        input  data_out, rvalid, busy, parity_err
    );

    modport slave (
        input  address, ren, wen, be, data_in,
        output data_out, rvalid, busy, parity_err
    );

endinterface

// File: rtl/ram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once, emitting a zero-write strobe.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int addrwidth      = 8,
    parameter int clear_on_reset = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 busy,
    output logic [addrwidth-1:0] clr_addr,
    output logic                 clr_we,
    output ram_state_t           state
);

    localparam ram_state_t RESET_STATE = (clear_on_reset != 0) ? RAM_CLEAR : RAM_IDLE;

    ram_state_t           state_q, state_d;
    logic [addrwidth-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        case (state_q)
            RAM_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RAM_IDLE;
                end
            end
            RAM_IDLE: begin
                busy = 1'b0;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/ram_pipe.sv
// Single-clock byte-writable RAM with write-first reads, 1- or 2-cycle read latency
// and a post-reset clear. Optional per-byte even parity under `RAM_PARITY_EN.
module ram_pipe
    import ram_pkg::*;
#(
    parameter int addrwidth      = 8,
    parameter int datawidth      = 8,
    parameter int rdlatency      = 1,
    parameter int clear_on_reset = 1
) (
    input logic      clk,
    input logic      rst,
    ram_pipe_if.slave bus
);

    localparam int nbytes = datawidth / BYTE_W;
    localparam int depth  = 1 << addrwidth;

    logic                 busy;
    logic                 clr_we;
    logic [addrwidth-1:0] clr_addr;
    ram_state_t           clr_state;
    logic                 idle;

    ram_clear_fsm #(
        .addrwidth      (addrwidth),
        .clear_on_reset (clear_on_reset)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .state    (clr_state)
    );

    assign idle     = (clr_state == RAM_IDLE);
    assign bus.busy = busy;

    // Write port: the clear sequencer owns it while busy, user requests are dropped.
    logic                 wr_en;
    logic [addrwidth-1:0] wr_addr;
    logic [datawidth-1:0] wr_data;
    logic [nbytes-1:0]    wr_be;

    always_comb begin
        wr_en   = bus.wen & idle;
        wr_addr = bus.address;
        wr_data = bus.data_in;
        wr_be   = bus.be;
        if (busy) begin
            wr_en   = clr_we;
            wr_addr = clr_addr;
            wr_data = '0;
            wr_be   = '1;
        end
    end

    logic [datawidth-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        for (int i = 0; i < nbytes; i++) begin
            if (wr_en && wr_be[i]) begin
                mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read port: a same-cycle write to the same address is merged in byte by byte.
    logic                 rd_acc;
    logic [datawidth-1:0] rd_old;
    logic [datawidth-1:0] rd_word;
    logic                 rd_perr;

    assign rd_acc = bus.ren & idle;
    assign rd_old = mem_q[bus.address];

    always_comb begin
        rd_word = rd_old;
        for (int i = 0; i < nbytes; i++) begin
            if (wr_en && wr_be[i]) begin
                rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [nbytes-1:0] par_q [depth];
    logic [nbytes-1:0] wr_par;
    logic [nbytes-1:0] rd_par;
    logic [nbytes-1:0] rd_calc;

    always_comb begin
        wr_par  = '0;
        rd_par  = '0;
        rd_calc = '0;
        for (int i = 0; i < nbytes; i++) begin
            wr_par[i]  = byte_parity(wr_data[i*BYTE_W +: BYTE_W]);
            rd_par[i]  = (wr_en && wr_be[i]) ? wr_par[i] : par_q[bus.address][i];
            rd_calc[i] = byte_parity(rd_word[i*BYTE_W +: BYTE_W]);
        end
        rd_perr = |(rd_calc ^ rd_par);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < nbytes; i++) begin
            if (wr_en && wr_be[i]) begin
                par_q[wr_addr][i] <= wr_par[i];
            end
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    // First output stage: registered array output. Data holds between reads.
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_perr_q, s1_perr_d;
    logic [datawidth-1:0] s1_data_q, s1_data_d;

    always_comb begin
        s1_valid_d = rd_acc;
        s1_perr_d  = rd_acc & rd_perr;
        s1_data_d  = rd_acc ? rd_word : s1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_perr_q  <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_perr_q  <= s1_perr_d;
            s1_data_q  <= s1_data_d;
        end
    end

    generate
        if (rdlatency == 2) begin : g_lat2
            logic                 s2_valid_q, s2_valid_d;
            logic                 s2_perr_q, s2_perr_d;
            logic [datawidth-1:0] s2_data_q, s2_data_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_perr_d  = s1_perr_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_perr_q  <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_perr_q  <= s2_perr_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign bus.rvalid     = s2_valid_q;
            assign bus.data_out   = s2_data_q;
            assign bus.parity_err = s2_perr_q;
        end else begin : g_lat1
            assign bus.rvalid     = s1_valid_q;
            assign bus.data_out   = s1_data_q;
            assign bus.parity_err = s1_perr_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_pipe.sv
// Directed bench for ram_pipe: latency-1 and latency-2 instances share stimulus,
// a third instance without clear checks immediate availability after reset.
module tb_ram_pipe;

    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_pipe_if #(.addrwidth(AW), .datawidth(DW)) bus1 ();
    ram_pipe_if #(.addrwidth(AW), .datawidth(DW)) bus2 ();
    ram_pipe_if #(.addrwidth(AW), .datawidth(8))  bus3 ();

    assign bus2.address = bus1.address;
    assign bus2.ren     = bus1.ren;
    assign bus2.wen     = bus1.wen;
    assign bus2.be      = bus1.be;
    assign bus2.data_in = bus1.data_in;

    ram_pipe #(.addrwidth(AW), .datawidth(DW), .rdlatency(1), .clear_on_reset(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    ram_pipe #(.addrwidth(AW), .datawidth(DW), .rdlatency(2), .clear_on_reset(1)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    ram_pipe #(.addrwidth(AW), .datawidth(8), .rdlatency(1), .clear_on_reset(0)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    task automatic idle_inputs();
        bus1.address = '0;
        bus1.ren     = 1'b0;
        bus1.wen     = 1'b0;
        bus1.be      = '0;
        bus1.data_in = '0;
        bus3.address = '0;
        bus3.ren     = 1'b0;
        bus3.wen     = 1'b0;
        bus3.be      = '0;
        bus3.data_in = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        bus1.address = a;
        bus1.data_in = d;
        bus1.be      = b;
        bus1.wen     = 1'b1;
        bus1.ren     = 1'b0;
        step();
        bus1.wen = 1'b0;
    endtask

    // One isolated access (read, optionally with a same-cycle write), checked on both latencies.
    task automatic do_access(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                             input logic [3:0] b, input logic [DW-1:0] exp, input logic exp_perr,
                             input string tag);
        bus1.address = a;
        bus1.data_in = d;
        bus1.be      = b;
        bus1.wen     = wr;
        bus1.ren     = 1'b1;
        step();
        bus1.ren = 1'b0;
        bus1.wen = 1'b0;
        n_vec++;
        if (bus1.rvalid !== 1'b1 || bus1.data_out !== exp || bus1.parity_err !== exp_perr) begin
            n_err++;
            $display("FAIL %s lat1: rvalid=%b data=%h perr=%b, want rvalid=1 data=%h perr=%b",
                     tag, bus1.rvalid, bus1.data_out, bus1.parity_err, exp, exp_perr);
        end
        n_vec++;
        if (bus2.rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL %s lat2 early: rvalid=%b, want 0", tag, bus2.rvalid);
        end
        step();
        n_vec++;
        if (bus1.rvalid !== 1'b0 || bus1.data_out !== exp) begin
            n_err++;
            $display("FAIL %s lat1 hold: rvalid=%b data=%h, want rvalid=0 data=%h",
                     tag, bus1.rvalid, bus1.data_out, exp);
        end
        n_vec++;
        if (bus2.rvalid !== 1'b1 || bus2.data_out !== exp || bus2.parity_err !== exp_perr) begin
            n_err++;
            $display("FAIL %s lat2: rvalid=%b data=%h perr=%b, want rvalid=1 data=%h perr=%b",
                     tag, bus2.rvalid, bus2.data_out, bus2.parity_err, exp, exp_perr);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus1.busy !== 1'b1 || bus1.rvalid !== 1'b0 || bus1.data_out !== '0 || bus1.parity_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset lat1: busy=%b rvalid=%b data=%h perr=%b, want 1 0 0 0",
                     bus1.busy, bus1.rvalid, bus1.data_out, bus1.parity_err);
        end
        n_vec++;
        if (bus2.busy !== 1'b1 || bus2.rvalid !== 1'b0 || bus2.data_out !== '0) begin
            n_err++;
            $display("FAIL reset lat2: busy=%b rvalid=%b data=%h, want 1 0 0",
                     bus2.busy, bus2.rvalid, bus2.data_out);
        end
        n_vec++;
        if (bus3.busy !== 1'b0 || bus3.rvalid !== 1'b0 || bus3.data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset noclear: busy=%b rvalid=%b data=%h, want 0 0 00",
                     bus3.busy, bus3.rvalid, bus3.data_out);
        end
        rst = 1'b0;
    endtask

    // Requests held asserted for the whole clear must all be dropped.
    task automatic test_clear_drop();
        int cnt;
        bus1.address = 4'd7;
        bus1.data_in = 32'hFFFF_FFFF;
        bus1.be      = 4'hF;
        bus1.wen     = 1'b1;
        bus1.ren     = 1'b1;
        cnt = 0;
        while (bus1.busy === 1'b1 && cnt < 40) begin
            n_vec++;
            if (bus1.rvalid !== 1'b0 || bus2.rvalid !== 1'b0 || bus2.busy !== 1'b1) begin
                n_err++;
                $display("FAIL clear_busy cycle %0d: rvalid1=%b rvalid2=%b busy2=%b, want 0 0 1",
                         cnt, bus1.rvalid, bus2.rvalid, bus2.busy);
            end
            cnt++;
            step();
        end
        idle_inputs();
        n_vec++;
        if (cnt != 16 || bus2.busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_len: busy cycles=%0d busy2=%b, want 16 and 0", cnt, bus2.busy);
        end
        repeat (2) begin
            step();
            n_vec++;
            if (bus1.rvalid !== 1'b0 || bus2.rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL dropped_read: rvalid1=%b rvalid2=%b, want 0 0", bus1.rvalid, bus2.rvalid);
            end
        end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < 16; a++) begin
            do_access(4'(a), 1'b0, '0, 4'h0, 32'h0, 1'b0, $sformatf("clear_rd%0d", a));
        end
    endtask

    task automatic test_byte_enables();
        do_write(4'd3, 32'hAABB_CCDD, 4'b1111);
        do_write(4'd3, 32'h1122_3344, 4'b0101);
        do_access(4'd3, 1'b0, '0, 4'h0, 32'hAA22_CC44, 1'b0, "be_merge");
        do_write(4'd3, 32'hFFFF_FFFF, 4'b0000);
        do_access(4'd3, 1'b0, '0, 4'h0, 32'hAA22_CC44, 1'b0, "be_zero_noop");
    endtask

    task automatic test_write_first();
        do_access(4'd5, 1'b1, 32'h0000_005A, 4'hF, 32'h0000_005A, 1'b0, "rw_full");
        do_access(4'd5, 1'b0, '0, 4'h0, 32'h0000_005A, 1'b0, "rw_full_stored");
        do_access(4'd3, 1'b1, 32'h5A5A_5A5A, 4'b0010, 32'hAA22_5A44, 1'b0, "rw_partial");
        do_access(4'd3, 1'b0, '0, 4'h0, 32'hAA22_5A44, 1'b0, "rw_partial_stored");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v [3];
        logic          e1v, e2v;
        logic [DW-1:0] e1d, e2d;
        v[0] = 32'h1111_1111;
        v[1] = 32'h2222_2222;
        v[2] = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            do_write(4'(i + 1), v[i], 4'hF);
        end
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                bus1.address = 4'(c + 1);
                bus1.ren     = 1'b1;
            end else begin
                bus1.ren = 1'b0;
            end
            step();
            e1v = (c < 3);
            e1d = v[(c < 3) ? c : 2];
            e2v = (c >= 1 && c < 4);
            e2d = v[(c == 0) ? 0 : ((c < 4) ? c - 1 : 2)];
            n_vec++;
            if (bus1.rvalid !== e1v || bus1.data_out !== e1d) begin
                n_err++;
                $display("FAIL b2b lat1 c%0d: rvalid=%b data=%h, want %b %h",
                         c, bus1.rvalid, bus1.data_out, e1v, e1d);
            end
            n_vec++;
            if (bus2.rvalid !== e2v || (c > 0 && bus2.data_out !== e2d)) begin
                n_err++;
                $display("FAIL b2b lat2 c%0d: rvalid=%b data=%h, want %b %h",
                         c, bus2.rvalid, bus2.data_out, e2v, e2d);
            end
        end
        bus1.ren = 1'b0;
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        dut1.mem_q[2] = dut1.mem_q[2] ^ 32'h0000_0001;
        dut2.mem_q[2] = dut2.mem_q[2] ^ 32'h0000_0001;
        do_access(4'd2, 1'b0, '0, 4'h0, 32'h2222_2223, 1'b1, "parity_flip");
        do_access(4'd1, 1'b0, '0, 4'h0, 32'h1111_1111, 1'b0, "parity_clean");
    endtask
`endif

    // Reset mid-read cancels the read; the clear restarts; no-clear instance works at once.
    task automatic test_reset_mid();
        int cnt;
        bus1.address = 4'd3;
        bus1.ren     = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        bus1.ren = 1'b0;
        n_vec++;
        if (bus1.rvalid !== 1'b0 || bus1.data_out !== '0 || bus1.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid lat1: rvalid=%b data=%h busy=%b, want 0 0 1",
                     bus1.rvalid, bus1.data_out, bus1.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (bus1.busy === 1'b1 && cnt < 40) begin
            if (cnt == 0) begin
                bus3.address = 4'd9;
                bus3.data_in = 8'hC3;
                bus3.be      = 1'b1;
                bus3.wen     = 1'b1;
            end else if (cnt == 1) begin
                bus3.wen = 1'b0;
                bus3.ren = 1'b1;
            end else if (cnt == 2) begin
                bus3.ren = 1'b0;
                n_vec++;
                if (bus3.rvalid !== 1'b1 || bus3.data_out !== 8'hC3) begin
                    n_err++;
                    $display("FAIL noclear_first: rvalid=%b data=%h, want 1 c3", bus3.rvalid, bus3.data_out);
                end
            end
            n_vec++;
            if (bus2.rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid lat2 cycle %0d: rvalid=%b, want 0", cnt, bus2.rvalid);
            end
            cnt++;
            step();
        end
        idle_inputs();
        n_vec++;
        if (cnt != 16) begin
            n_err++;
            $display("FAIL reclear_len: busy cycles=%0d, want 16", cnt);
        end
        do_access(4'd3, 1'b0, '0, 4'h0, 32'h0, 1'b0, "reclear_rd3");
    endtask

    initial begin
        test_reset();
        test_clear_drop();
        test_clear_reads();
        test_byte_enables();
        test_write_first();
        test_back_to_back();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
